// File: rtl/mult_sched_if.sv
// Request/response bundle for the shared signed multiplier scheduler.
interface mult_sched_if #(
  parameter int unsigned WIDTH = 16
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_p;
  logic               busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/mult_sched.sv
// Two-requester round-robin scheduler sharing one pipelined radix-4 Booth
// signed multiplier, with a credit-guarded in-order result FIFO.
module mult_sched #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  mult_sched_if.slave io_bus
);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned NPP = WIDTH / 2;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(FIFO_DEPTH - 1);

  logic             r_ptr;
  logic [CW-1:0]    r_credit;
  logic             w_permit, w_gnt0, w_gnt1, w_issue, w_issue_id, w_pop, w_push;
  logic [WIDTH-1:0] w_a, w_b;

  // Arbitration: a lone requester wins, a tie goes to the pointer; reset blocks issue.
  always_comb begin
    w_permit   = rst_n & (r_credit < DEPTH_C);
    w_gnt0     = w_permit & io_bus.req0_valid & (~io_bus.req1_valid | ~r_ptr);
    w_gnt1     = w_permit & io_bus.req1_valid & (~io_bus.req0_valid | r_ptr);
    w_issue    = w_gnt0 | w_gnt1;
    w_issue_id = w_gnt1;
    w_a        = w_gnt1 ? io_bus.req1_a : io_bus.req0_a;
    w_b        = w_gnt1 ? io_bus.req1_b : io_bus.req0_b;
  end

  assign io_bus.req0_ready = w_gnt0;
  assign io_bus.req1_ready = w_gnt1;

  logic [PW-1:0]  w_a_ext, w_row, w_cs_s, w_cs_c, w_t;
  logic [WIDTH:0] w_b_pad;
  logic [PW-1:0]  w_pp [NPP];

  // Radix-4 Booth partial products, then carry-save compression down to two rows.
  always_comb begin
    w_a_ext = {{WIDTH{w_a[WIDTH-1]}}, w_a};
    w_b_pad = {w_b, 1'b0};
    for (int i = 0; i < NPP; i++) begin
      case (w_b_pad[2*i +: 3])
        3'b001, 3'b010: w_row = w_a_ext;
        3'b011:         w_row = w_a_ext << 1;
        3'b100:         w_row = -(w_a_ext << 1);
        3'b101, 3'b110: w_row = -w_a_ext;
        default:        w_row = '0;
      endcase
      w_pp[i] = w_row << (2 * i);
    end
    w_cs_s = w_pp[0];
    w_cs_c = w_pp[1];
    w_t    = '0;
    for (int i = 2; i < NPP; i++) begin
      w_t    = w_cs_s ^ w_cs_c ^ w_pp[i];
      w_cs_c = ((w_cs_s & w_cs_c) | (w_cs_s & w_pp[i]) | (w_cs_c & w_pp[i])) << 1;
      w_cs_s = w_t;
    end
  end

  logic          r_s1_vld, r_s1_id, r_s2_vld, r_s2_id;
  logic [PW-1:0] r_s1_sum, r_s1_cry, r_s2_p;

  // Stage 1 holds the redundant sum/carry pair; stage 2 holds the resolved product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_id  <= 1'b0;
      r_s1_sum <= '0;
      r_s1_cry <= '0;
      r_s2_vld <= 1'b0;
      r_s2_id  <= 1'b0;
      r_s2_p   <= '0;
    end else begin
      r_s1_vld <= w_issue;
      r_s2_vld <= r_s1_vld;
      if (w_issue) begin
        r_s1_id  <= w_issue_id;
        r_s1_sum <= w_cs_s;
        r_s1_cry <= w_cs_c;
      end
      if (r_s1_vld) begin
        r_s2_id <= r_s1_id;
        r_s2_p  <= r_s1_sum + r_s1_cry;
      end
    end
  end

  logic [PW:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_rsp_vld;

  assign w_rsp_vld = (r_cnt != '0);
  assign w_pop     = w_rsp_vld & io_bus.rsp_ready;
  assign w_push    = r_s2_vld;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {r_s2_id, r_s2_p};
  end

  // FIFO pointers, credit and round-robin pointer; credit bounds FIFO occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_credit <= '0;
      r_ptr    <= 1'b0;
    end else begin
      if (w_push) r_wr <= (r_wr == LAST_IDX) ? '0 : r_wr + AW'(1);
      if (w_pop)  r_rd <= (r_rd == LAST_IDX) ? '0 : r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
      case ({w_issue, w_pop})
        2'b10:   r_credit <= r_credit + CW'(1);
        2'b01:   r_credit <= r_credit - CW'(1);
        default: ;
      endcase
      if (w_issue) r_ptr <= ~w_issue_id;
    end
  end

  assign io_bus.rsp_valid = w_rsp_vld;
  assign {io_bus.rsp_id, io_bus.rsp_p} = w_rsp_vld ? r_mem[r_rd] : '0;
  assign io_bus.busy      = (r_credit != '0);
endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: directed vector table, corner sequences
// and a randomized phase scored against a queue-based reference model.
module tb_mult_sched;
  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NV    = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mult_sched_if #(.WIDTH(W)) bus ();

  mult_sched #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { logic id; logic [2*W-1:0] p; int cyc; } exp_t;
  typedef struct { logic id; logic [W-1:0] a; logic [W-1:0] b; logic [2*W-1:0] p; } vec_t;

  exp_t           q[$];
  int             grant_log[$];
  int             pop_log[$];
  logic           m_ptr  = 1'b0;
  logic           hold   = 1'b0;
  logic           hold_id;
  logic [2*W-1:0] hold_p;
  vec_t           vt[NV];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sa * sb;
    return r[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return W'(16'h8000);
      1:       return W'(16'h7FFF);
      2:       return '0;
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: queue of issued-but-unpopped results drives every expectation.
  always @(negedge clk) begin
    logic e0, e1, win, ev;
    if (!rst_n) begin
      q.delete();
      m_ptr = 1'b0;
      hold  = 1'b0;
      chk("reset_ctrl", 64'({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.busy, bus.rsp_id}), 64'd0);
      chk("reset_rsp_p", 64'(bus.rsp_p), 64'd0);
    end else begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (q.size() < DEPTH && (bus.req0_valid || bus.req1_valid)) begin
        win = (bus.req0_valid && bus.req1_valid) ? m_ptr : bus.req1_valid;
        e0  = ~win;
        e1  = win;
      end
      chk("req0_ready", 64'(bus.req0_ready), 64'(e0));
      chk("req1_ready", 64'(bus.req1_ready), 64'(e1));
      ev = 1'b0;
      if (q.size() != 0) ev = (q[0].cyc + 3 <= cyc);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      chk("busy", 64'(bus.busy), 64'(q.size() != 0));
      if (hold) begin
        chk("hold_id", 64'(bus.rsp_id), 64'(hold_id));
        chk("hold_p", 64'(bus.rsp_p), 64'(hold_p));
      end
      if (bus.rsp_valid && bus.rsp_ready && q.size() != 0) begin
        chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
        chk("rsp_p", 64'(bus.rsp_p), 64'(q[0].p));
        pop_log.push_back(int'(bus.rsp_id));
        void'(q.pop_front());
      end
      hold    = bus.rsp_valid && !bus.rsp_ready;
      hold_id = bus.rsp_id;
      hold_p  = bus.rsp_p;
      if (e0) begin
        q.push_back('{1'b0, prod(bus.req0_a, bus.req0_b), cyc});
        grant_log.push_back(0);
        m_ptr = 1'b1;
      end else if (e1) begin
        q.push_back('{1'b1, prod(bus.req1_a, bus.req1_b), cyc});
        grant_log.push_back(1);
        m_ptr = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    bus.req0_a = pick();
    bus.req0_b = pick();
    bus.req1_a = pick();
    bus.req1_b = pick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    grant_log.delete();
    pop_log.delete();
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < max_cyc && !idle; k++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1'b1;
    end
    chk(name, 64'(idle), 64'd1);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int t;
    vt[0] = '{1'b0, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vt[1] = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
    vt[2] = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    vt[3] = '{1'b1, 16'h0000, 16'h8000, 32'h00000000};
    vt[4] = '{1'b0, 16'h8000, 16'h7FFF, 32'hC0008000};
    vt[5] = '{1'b1, 16'h0003, 16'hFFFB, 32'hFFFFFFF1};
    vt[6] = '{1'b0, 16'h1234, 16'h0010, 32'h00012340};

    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Directed vectors: exact products and N+3 latency on an idle pipeline.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (vt[i].id) begin
        bus.req1_valid = 1'b1; bus.req1_a = vt[i].a; bus.req1_b = vt[i].b;
      end else begin
        bus.req0_valid = 1'b1; bus.req0_a = vt[i].a; bus.req0_b = vt[i].b;
      end
      got = 1'b0;
      t   = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (vt[i].id ? bus.req1_ready : bus.req0_ready) begin
          got = 1'b1;
          t   = cyc;
        end
      end
      chk("vec_grant", 64'(got), 64'd1);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (bus.rsp_valid) begin
          got = 1'b1;
          chk("vec_latency", 64'(cyc - t), 64'd3);
          chk("vec_p", 64'(bus.rsp_p), 64'(vt[i].p));
          chk("vec_id", 64'(bus.rsp_id), 64'(vt[i].id));
        end
      end
      chk("vec_rsp_seen", 64'(got), 64'd1);
      step();
    end

    // Fairness: both valid from reset alternate 0,1,0,1.
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 40 && grant_log.size() < 8; k++) begin
      rand_ops();
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("fair_grants", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("fair_grant_order", 64'(grant_log[i]), 64'(i % 2));
    wait_idle("fair_drain", 30);
    chk("fair_pops", 64'(pop_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) chk("fair_rsp_id", 64'(pop_log[i]), 64'(i % 2));

    // Backpressure: exactly DEPTH transfers, then stall; release drains in order.
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rand_ops();
      step();
    end
    chk("bp_transfers", 64'(grant_log.size()), 64'(DEPTH));
    @(negedge clk);
    chk("bp_ready_low", 64'(bus.req0_ready), 64'd0);
    chk("bp_busy", 64'(bus.busy), 64'd1);
    step();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      step();
    end
    bus.req0_valid = 1'b0;
    chk("bp_resumed", 64'(grant_log.size() > DEPTH), 64'd1);
    wait_idle("bp_drain", 30);
    chk("bp_no_loss", 64'(pop_log.size()), 64'(grant_log.size()));

    // Reset while ops are buffered and in flight: all of them are discarded.
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      step();
    end
    bus.req0_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("midrst_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(bus.rsp_valid), 64'd0);
    end
    chk("midrst_no_pops", 64'(pop_log.size()), 64'd0);
    step();

    // Randomized traffic with random backpressure.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 3) != 0);
      bus.rsp_ready  = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    wait_idle("rand_drain", 30);
    chk("rand_no_loss", 64'(pop_log.size()), 64'(grant_log.size()));
    chk("rand_model_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
